// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int ZERO_REG         = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, hard-wired zero register and,
// when REGFILE_BYPASS_EN is defined, same-cycle forwarding of writeback data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]               rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             busy,
  input  logic                            wb_en,
  input  logic [ADDR_W-1:0]               wb_addr,
  input  logic [DATA_W-1:0]               wb_data,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            rd_busy
);

  logic is_zero;
  logic fwd;

  assign is_zero = (rd_addr == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  assign fwd = wb_en && (wb_addr != ADDR_W'(ZERO_REG)) && (wb_addr == rd_addr);
`else
  // Without forwarding the writeback inputs are intentionally ignored.
  logic unused_bypass;
  assign fwd           = 1'b0;
  assign unused_bypass = ^{wb_en, wb_addr, wb_data};
`endif

  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (fwd) begin
      rd_data = wb_data;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard and busy count.
// Optional same-cycle read forwarding is enabled by defining REGFILE_BYPASS_EN.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic              PA_busy,
  output logic              PB_busy,
  input  logic              Issue_en,
  input  logic [ADDR_W-1:0] Issue_rd,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] PW,
  output logic [ADDR_W:0]   Pend_cnt
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]                 pend_q, pend_d;

  logic wr_ok, iss_ok, inc, dec;
  logic wb_fwd_en;

  assign wr_ok  = WE && (RW != ADDR_W'(ZERO_REG));
  assign iss_ok = Issue_en && (Issue_rd != ADDR_W'(ZERO_REG));

  // Count moves only on real busy transitions; a same-edge issue to the
  // written register keeps it busy, so that writeback does not decrement.
  assign inc = iss_ok && !busy_q[Issue_rd];
  assign dec = wr_ok && busy_q[RW] && !(iss_ok && (Issue_rd == RW));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[RW] = PW;
      busy_d[RW] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[Issue_rd] = 1'b1;
    end
    regs_d[ZERO_REG] = '0;
    busy_d[ZERO_REG] = 1'b0;
    pend_d = pend_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign Pend_cnt = pend_q;

  // A write presented during reset must not be forwarded to the read ports.
  assign wb_fwd_en = WE && Rst_n;

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_a (
    .rd_addr (RA),
    .regs    (regs_q),
    .busy    (busy_q),
    .wb_en   (wb_fwd_en),
    .wb_addr (RW),
    .wb_data (PW),
    .rd_data (PA),
    .rd_busy (PA_busy)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_b (
    .rd_addr (RB),
    .regs    (regs_q),
    .busy    (busy_q),
    .wb_en   (wb_fwd_en),
    .wb_addr (RW),
    .wb_data (PW),
    .rd_data (PB),
    .rd_busy (PB_busy)
  );

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench for scoreboard_regfile: directed scenarios then random
// traffic, compared against an array-based model of registers and busy flags.
module tb_scoreboard_regfile;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   logic              Clk = 1'b0;
   logic              Rst_n = 1'b0;
   logic [ADDR_W-1:0] RA = '0, RB = '0, Issue_rd = '0, RW = '0;
   logic [DATA_W-1:0] PW = '0;
   logic              Issue_en = 1'b0, WE = 1'b0;
   logic [DATA_W-1:0] PA, PB;
   logic              PA_busy, PB_busy;
   logic [ADDR_W:0]   Pend_cnt;

   int asserts = 0;
   int fails   = 0;

   logic [DATA_W-1:0] modelRegs [NUM_REGS];
   bit                modelBusy [NUM_REGS];

   scoreboard_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .RA       (RA),
      .RB       (RB),
      .PA       (PA),
      .PB       (PB),
      .PA_busy  (PA_busy),
      .PB_busy  (PB_busy),
      .Issue_en (Issue_en),
      .Issue_rd (Issue_rd),
      .WE       (WE),
      .RW       (RW),
      .PW       (PW),
      .Pend_cnt (Pend_cnt)
   );

   // Free-running clock, 10 time units per period
   always #5 Clk = ~Clk;

   // Clears the reference model, mirroring an asynchronous reset
   task automatic modelReset();
      for (int i = 0; i < NUM_REGS; i++) begin
         modelRegs[i] = '0;
         modelBusy[i] = 1'b0;
      end
   endtask

   // Applies the architectural rules for one rising edge: write clears busy,
   // then an issue sets busy, so a same-edge issue wins; register 0 is inert
   task automatic modelEdge();
      if (WE && RW != 0) begin
         modelRegs[RW] = PW;
         modelBusy[RW] = 1'b0;
      end
      if (Issue_en && Issue_rd != 0) modelBusy[Issue_rd] = 1'b1;
   endtask

   // Compares both read ports and the busy count against the model
   task automatic checkOutput(input string tag);
      logic [DATA_W-1:0] expPa, expPb;
      logic              expAb, expBb;
      int                expCnt;
      expPa = modelRegs[RA];
      expPb = modelRegs[RB];
      expAb = modelBusy[RA];
      expBb = modelBusy[RB];
`ifdef REGFILE_BYPASS_EN
      if (Rst_n && WE && RW != 0 && RW == RA) begin
         expPa = PW;
         expAb = 1'b0;
      end
      if (Rst_n && WE && RW != 0 && RW == RB) begin
         expPb = PW;
         expBb = 1'b0;
      end
`endif
      if (RA == 0) begin
         expPa = '0;
         expAb = 1'b0;
      end
      if (RB == 0) begin
         expPb = '0;
         expBb = 1'b0;
      end
      expCnt = 0;
      for (int i = 0; i < NUM_REGS; i++) expCnt += int'(modelBusy[i]);

      asserts++;
      assert (PA === expPa) else begin
         fails++;
         $error("[TB] FAIL %s PA: got %h expected %h", tag, PA, expPa);
      end
      asserts++;
      assert (PB === expPb) else begin
         fails++;
         $error("[TB] FAIL %s PB: got %h expected %h", tag, PB, expPb);
      end
      asserts++;
      assert (PA_busy === expAb) else begin
         fails++;
         $error("[TB] FAIL %s PA_busy: got %b expected %b", tag, PA_busy, expAb);
      end
      asserts++;
      assert (PB_busy === expBb) else begin
         fails++;
         $error("[TB] FAIL %s PB_busy: got %b expected %b", tag, PB_busy, expBb);
      end
      asserts++;
      assert (Pend_cnt === (ADDR_W+1)'(expCnt)) else begin
         fails++;
         $error("[TB] FAIL %s Pend_cnt: got %0d expected %0d", tag, Pend_cnt, expCnt);
      end
   endtask

   // Drives one cycle of inputs after the falling edge, checks the
   // pre-edge view, then advances the model on the rising edge
   task automatic applyStimulus(input logic we, input int rw, input logic [DATA_W-1:0] pw,
                                input logic ie, input int ird, input int ra, input int rb,
                                input string tag);
      @(negedge Clk);
      WE       = we;
      RW       = ADDR_W'(rw);
      PW       = pw;
      Issue_en = ie;
      Issue_rd = ADDR_W'(ird);
      RA       = ADDR_W'(ra);
      RB       = ADDR_W'(rb);
      #1;
      checkOutput(tag);
      @(posedge Clk);
      if (Rst_n) modelEdge();
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      modelReset();
      #1;
      checkOutput("reset_state");
      @(negedge Clk);
      Rst_n = 1'b1;

      // Register 0 ignores writes and issues
      applyStimulus(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, "zero_wr");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, "zero_rd");

      // Issue, observe busy, write back, observe data
      applyStimulus(0, 0, 0, 1, 3, 0, 3, "iss3");
      applyStimulus(1, 3, 32'h1234_5678, 0, 0, 3, 0, "wb3");
      applyStimulus(0, 0, 0, 0, 0, 3, 3, "rd3");

      // Same-edge issue and writeback to one register
      applyStimulus(1, 9, 32'h0000_00A5, 1, 9, 9, 0, "same9");
      applyStimulus(0, 0, 0, 0, 0, 9, 9, "rd9");

      // Re-issue of a busy register and writeback to an idle one
      applyStimulus(0, 0, 0, 1, 9, 9, 0, "reiss9");
      applyStimulus(1, 12, 32'hCAFE_0012, 0, 0, 12, 9, "wb_idle12");
      applyStimulus(1, 9, 32'h0000_0099, 0, 0, 9, 12, "wb9");

      // Write while reading the same register on both ports
      applyStimulus(1, 4, 32'h0000_0011, 0, 0, 0, 0, "wr4_old");
      applyStimulus(1, 4, 32'h0000_0055, 0, 0, 4, 4, "wr4_fwd");
      applyStimulus(0, 0, 0, 0, 0, 4, 4, "rd4_new");

      // Fill every register's busy flag, then drain them all
      for (int r = 1; r < NUM_REGS; r++) applyStimulus(0, 0, 0, 1, r, r, r - 1, "fill");
      applyStimulus(0, 0, 0, 0, 0, 1, NUM_REGS - 1, "full");
      asserts++;
      assert (Pend_cnt === (ADDR_W+1)'(NUM_REGS - 1)) else begin
         fails++;
         $error("[TB] FAIL peak Pend_cnt: got %0d expected %0d", Pend_cnt, NUM_REGS - 1);
      end
      for (int r = 1; r < NUM_REGS; r++) applyStimulus(1, r, 32'h100 + r, 0, 0, r, r, "drain");
      applyStimulus(0, 0, 0, 0, 0, 5, 17, "empty");
      asserts++;
      assert (Pend_cnt === '0) else begin
         fails++;
         $error("[TB] FAIL drained Pend_cnt: got %0d expected 0", Pend_cnt);
      end

      // Asynchronous reset in the middle of a cycle with strobes active
      applyStimulus(1, 5, 32'hDEAD_BEEF, 1, 7, 0, 0, "pre_rst");
      applyStimulus(0, 0, 0, 0, 0, 5, 7, "pre_rst_rd");
      @(negedge Clk);
      #2;
      Rst_n    = 1'b0;
      WE       = 1'b1;
      RW       = ADDR_W'(5);
      PW       = 32'h0BAD_F00D;
      Issue_en = 1'b1;
      Issue_rd = ADDR_W'(7);
      RA       = ADDR_W'(5);
      RB       = ADDR_W'(7);
      #1;
      modelReset();
      checkOutput("rst_async");
      @(posedge Clk);
      #1;
      checkOutput("rst_hold");
      @(negedge Clk);
      Rst_n    = 1'b1;
      WE       = 1'b0;
      Issue_en = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 5, 7, "post_rst");

      // Randomized traffic with frequent address collisions
      for (int n = 0; n < 400; n++) begin
         int rw, ird, ra, rb;
         rw  = $urandom_range(0, NUM_REGS - 1);
         ird = ($urandom_range(0, 3) == 0) ? rw : $urandom_range(0, NUM_REGS - 1);
         ra  = ($urandom_range(0, 3) == 0) ? rw : $urandom_range(0, NUM_REGS - 1);
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, NUM_REGS - 1);
         applyStimulus(logic'($urandom_range(0, 1)), rw, $urandom,
                       logic'($urandom_range(0, 1)), ird, ra, rb, "random");
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 2, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
